// File: rtl/sgd_x_writeback_scheduler.sv
// rtl/sgd_x_writeback_scheduler.sv - per-epoch write-back sequencer for the engine x FIFOs
// Drains ENGINE_NUM x FIFOs in feature order and issues one host write command per burst.
module sgd_x_writeback_scheduler #(
    parameter int ENGINE_NUM       = 8,
    parameter int LINES_PER_ENGINE = 4,
    parameter int FEAT_PER_CHUNK   = ENGINE_NUM * 64,
    parameter int MAX_BURST_LINES  = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      started,
    input  logic [63:0]               addr_model,
    input  logic [31:0]               dimension,
    input  logic [31:0]               numEpochs,
    input  logic                      epoch_ready,
    input  logic [ENGINE_NUM*512-1:0] x_to_mem_rd_data,
    input  logic [ENGINE_NUM-1:0]     x_to_mem_empty,
    output logic [ENGINE_NUM-1:0]     x_to_mem_rd_en,
    output logic                      x_data_send_back_start,
    output logic [63:0]               x_data_send_back_addr,
    output logic [31:0]               x_data_send_back_length,
    output logic [511:0]              x_data_out,
    output logic                      x_data_out_valid,
    input  logic                      x_data_out_almost_full,
    output logic                      writeback_done,
    output logic [3:0]                error_flags,
    output logic [31:0]               state_counters
);
    localparam int EW = (ENGINE_NUM > 1) ? $clog2(ENGINE_NUM) : 1;
    localparam int IW = (LINES_PER_ENGINE > 1) ? $clog2(LINES_PER_ENGINE) : 1;
    localparam logic [31:0] CHUNK_LINES = 32'(ENGINE_NUM * LINES_PER_ENGINE);
    localparam logic [31:0] MAX_LINES   = 32'(MAX_BURST_LINES);
    localparam logic [ENGINE_NUM-1:0] ONE_E = ENGINE_NUM'(1);

    typedef enum logic [3:0] {
        S_IDLE, S_ARM, S_WAIT, S_CMD, S_DRAIN, S_EPOCH_END, S_DONE
    } state_t;

    state_t          r_state;
    logic            r_started_d;
    logic [1:0]      r_pending;
    logic [31:0]     r_num_epochs, r_epoch_idx, r_epoch_lines;
    logic [31:0]     r_line_off, r_burst_len, r_req_cnt;
    logic [63:0]     r_epoch_base, r_epoch_bytes;
    logic [EW-1:0]   r_eng, r_rd_eng;
    logic [IW-1:0]   r_inner;
    logic            r_rd_d1;
    logic            r_start, r_valid, r_done;
    logic [63:0]     r_addr;
    logic [31:0]     r_len;
    logic [511:0]    r_data;
    logic [3:0]      r_err;
    logic [15:0]     r_lines_sent;

    logic [32:0]     w_dim_up;
    logic [31:0]     w_chunks, w_epoch_lines, w_rem, w_blen;
    logic            w_req_done, w_rd_ok, w_dec;

    assign w_dim_up      = {1'b0, dimension} + 33'(FEAT_PER_CHUNK - 1);
    assign w_chunks      = 32'(w_dim_up / 33'(FEAT_PER_CHUNK));
    assign w_epoch_lines = w_chunks * CHUNK_LINES;
    assign w_rem         = r_epoch_lines - r_line_off;
    assign w_blen        = (w_rem > MAX_LINES) ? MAX_LINES : w_rem;
    assign w_req_done    = (r_req_cnt == r_burst_len);
    // Reads stop as soon as back-pressure rises; the host path absorbs the <=2 lines in flight.
    assign w_rd_ok       = (r_state == S_DRAIN) && !w_req_done && !x_data_out_almost_full
                           && !x_to_mem_empty[r_eng];
    assign w_dec         = (r_state == S_WAIT) && (r_pending != 2'd0);

    assign x_to_mem_rd_en          = w_rd_ok ? (ONE_E << r_eng) : '0;
    assign x_data_send_back_start  = r_start;
    assign x_data_send_back_addr   = r_addr;
    assign x_data_send_back_length = r_len;
    assign x_data_out              = r_data;
    assign x_data_out_valid        = r_valid;
    assign writeback_done          = r_done;
    assign error_flags             = r_err;
    assign state_counters          = {r_state, r_epoch_idx[11:0], r_lines_sent};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_started_d   <= 1'b0;
            r_pending     <= 2'd0;
            r_num_epochs  <= '0;
            r_epoch_idx   <= '0;
            r_epoch_lines <= '0;
            r_line_off    <= '0;
            r_burst_len   <= '0;
            r_req_cnt     <= '0;
            r_epoch_base  <= '0;
            r_epoch_bytes <= '0;
            r_eng         <= '0;
            r_rd_eng      <= '0;
            r_inner       <= '0;
            r_rd_d1       <= 1'b0;
            r_start       <= 1'b0;
            r_valid       <= 1'b0;
            r_done        <= 1'b0;
            r_addr        <= '0;
            r_len         <= '0;
            r_data        <= '0;
            r_err         <= '0;
            r_lines_sent  <= '0;
        end else begin
            r_started_d <= started;
            r_start     <= 1'b0;
            r_rd_d1     <= w_rd_ok;
            r_rd_eng    <= r_eng;
            r_valid     <= r_rd_d1;
            if (r_rd_d1) begin
                r_data       <= x_to_mem_rd_data[int'(r_rd_eng)*512 +: 512];
                r_lines_sent <= r_lines_sent + 16'd1;
            end
            if ((x_to_mem_rd_en & x_to_mem_empty) != '0)
                r_err[2] <= 1'b1;

            // Pending epochs saturate at two; a third unconsumed pulse is flagged.
            if (r_state != S_IDLE) begin
                if (epoch_ready && !w_dec) begin
                    if (r_pending == 2'd2) r_err[1] <= 1'b1;
                    else                   r_pending <= r_pending + 2'd1;
                end else if (!epoch_ready && w_dec) begin
                    r_pending <= r_pending - 2'd1;
                end
            end

            if (w_rd_ok) begin
                r_req_cnt <= r_req_cnt + 32'd1;
                if (r_inner == IW'(LINES_PER_ENGINE - 1)) begin
                    r_inner <= '0;
                    r_eng   <= (r_eng == EW'(ENGINE_NUM - 1)) ? '0 : r_eng + 1'b1;
                end else begin
                    r_inner <= r_inner + 1'b1;
                end
            end

            case (r_state)
                S_IDLE: if (started && !r_started_d) begin
                    r_done    <= 1'b0;
                    r_err     <= '0;
                    r_pending <= 2'd0;
                    r_state   <= S_ARM;
                end
                S_ARM: begin
                    r_epoch_base  <= addr_model;
                    r_epoch_lines <= w_epoch_lines;
                    r_epoch_bytes <= {32'd0, w_epoch_lines} << 6;
                    r_num_epochs  <= numEpochs;
                    r_epoch_idx   <= '0;
                    r_line_off    <= '0;
                    r_eng         <= '0;
                    r_inner       <= '0;
                    r_lines_sent  <= '0;
                    if (dimension == 32'd0) begin
                        r_err[0] <= 1'b1;
                        r_done   <= 1'b1;
                        r_state  <= S_DONE;
                    end else if (numEpochs == 32'd0) begin
                        r_done   <= 1'b1;
                        r_state  <= S_DONE;
                    end else begin
                        r_state  <= S_WAIT;
                    end
                end
                S_WAIT: if (r_pending != 2'd0) r_state <= S_CMD;
                S_CMD: begin
                    r_start     <= 1'b1;
                    r_addr      <= r_epoch_base + ({32'd0, r_line_off} << 6);
                    r_len       <= w_blen << 6;
                    r_burst_len <= w_blen;
                    r_req_cnt   <= '0;
                    r_state     <= S_DRAIN;
                end
                // Hold DRAIN until the last requested line has reached the output register.
                S_DRAIN: if (w_req_done && !r_rd_d1) begin
                    if (r_line_off + r_burst_len >= r_epoch_lines) begin
                        r_state <= S_EPOCH_END;
                    end else begin
                        r_line_off <= r_line_off + r_burst_len;
                        r_state    <= S_CMD;
                    end
                end
                S_EPOCH_END: begin
                    r_epoch_idx  <= r_epoch_idx + 32'd1;
                    r_epoch_base <= r_epoch_base + r_epoch_bytes;
                    r_line_off   <= '0;
                    if (r_epoch_idx + 32'd1 == r_num_epochs) begin
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_state <= S_WAIT;
                    end
                end
                S_DONE: if (!started) r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sgd_x_writeback_scheduler.sv
// tb/tb_sgd_x_writeback_scheduler.sv - randomized scoreboard bench for sgd_x_writeback_scheduler
module tb_sgd_x_writeback_scheduler;
    localparam int E = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              started = 1'b0;
    logic [63:0]       addr_model = '0;
    logic [31:0]       dimension = '0;
    logic [31:0]       numEpochs = '0;
    logic              epoch_ready = 1'b0;
    logic [E*512-1:0]  rd_data_r = '0;
    logic [E-1:0]      empty_r = '1;
    logic [E-1:0]      rd_en;
    logic              cmd_start;
    logic [63:0]       cmd_addr;
    logic [31:0]       cmd_len;
    logic [511:0]      dout;
    logic              dvalid;
    logic              af = 1'b0;
    logic              done;
    logic [3:0]        err;
    logic [31:0]       sc;

    int total = 0;
    int bad = 0;
    logic [95:0]  cmdq[$];
    logic [511:0] dq[$];
    logic [511:0] fq[E][$];
    bit af_mode = 0, e3_mode = 0, force3 = 0;
    int burst_rem = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    sgd_x_writeback_scheduler dut (
        .clk(clk), .rst(rst), .started(started), .addr_model(addr_model),
        .dimension(dimension), .numEpochs(numEpochs), .epoch_ready(epoch_ready),
        .x_to_mem_rd_data(rd_data_r), .x_to_mem_empty(empty_r), .x_to_mem_rd_en(rd_en),
        .x_data_send_back_start(cmd_start), .x_data_send_back_addr(cmd_addr),
        .x_data_send_back_length(cmd_len), .x_data_out(dout), .x_data_out_valid(dvalid),
        .x_data_out_almost_full(af), .writeback_done(done), .error_flags(err),
        .state_counters(sc)
    );

    task automatic check(input string nm, input logic [511:0] act, input logic [511:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Standard FIFOs with one-cycle read latency; engine 3 can be forced empty.
    always @(posedge clk) begin
        int sz;
        for (int e = 0; e < E; e++) begin
            sz = fq[e].size();
            if (!rst && rd_en[e] && sz > 0) begin
                rd_data_r[e*512 +: 512] <= fq[e].pop_front();
                sz = sz - 1;
            end
            empty_r[e] <= (sz == 0) || (e == 3 && force3);
        end
    end

    always @(negedge clk) begin
        cyc++;
        if (af_mode) begin
            if (cyc % 5 == 0) af = ~af;
        end else begin
            af = 1'b0;
        end
        force3 = e3_mode && ($urandom_range(0, 2) == 0);
    end

    always @(negedge clk) begin
        if (rst) begin
            burst_rem = 0;
        end else begin
            if ((rd_en & empty_r) != '0) begin
                bad++;
                $display("FAIL rd_on_empty: rd_en=%b empty=%b", rd_en, empty_r);
            end
            if ($countones(rd_en) > 1) begin
                bad++;
                $display("FAIL rd_en_onehot: rd_en=%b", rd_en);
            end
            if (cmd_start) begin
                if (burst_rem != 0) begin
                    bad++;
                    $display("FAIL cmd_overlap: %0d lines still owed, required 0", burst_rem);
                end
                if (cmdq.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_cmd: got addr=%h len=%0d, required none", cmd_addr, cmd_len);
                end else begin
                    check("cmd", {416'd0, cmd_addr, cmd_len}, {416'd0, cmdq.pop_front()});
                end
                burst_rem = int'(cmd_len / 64);
            end
            if (dvalid) begin
                if (burst_rem == 0) begin
                    bad++;
                    $display("FAIL data_outside_burst: got data with no command, required command first");
                end else begin
                    burst_rem--;
                end
                if (dq.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_data: got %h, required none", dout);
                end else begin
                    check("data", dout, dq.pop_front());
                end
            end
        end
    end

    task automatic build_model(input int unsigned dim, input int unsigned ne, input longint unsigned addr);
        longint unsigned chunks, lines, off, n;
        logic [511:0] w;
        chunks = (longint'(dim) + 511) / 512;
        lines  = chunks * 32;
        for (longint unsigned ep = 0; ep < ne; ep++) begin
            off = 0;
            while (off < lines) begin
                n = (lines - off > 64) ? 64 : lines - off;
                cmdq.push_back({64'(addr + ep * lines * 64 + off * 64), 32'(n * 64)});
                off += n;
            end
            for (longint unsigned c = 0; c < chunks; c++)
                for (int e = 0; e < E; e++)
                    for (int i = 0; i < 4; i++) begin
                        for (int k = 0; k < 16; k++) w[k*32 +: 32] = $urandom;
                        fq[e].push_back(w);
                        dq.push_back(w);
                    end
        end
    endtask

    task automatic wait_state(input logic [3:0] s, input bit eq, input string nm);
        int n = 0;
        while (((sc[31:28] == s) != eq) && n < 20000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20000) begin
            total++; bad++;
            $display("FAIL timeout_%s: state=%0d after %0d cycles, required %0d", nm, sc[31:28], n, s);
        end
    endtask

    task automatic pulse();
        @(negedge clk) epoch_ready = 1'b1;
        @(negedge clk) epoch_ready = 1'b0;
    endtask

    task automatic run_job(input int unsigned dim, input int unsigned ne, input logic [63:0] addr,
                           input bit extra);
        int n = 0;
        build_model(dim, ne, addr);
        dimension = dim; numEpochs = ne; addr_model = addr;
        @(negedge clk) started = 1'b1;
        repeat (3) @(negedge clk);
        if (dim == 0) check("dim0_done_3cyc", {511'd0, done}, 512'd1);
        if (dim != 0 && ne != 0) begin
            if (extra) begin
                wait_state(4'd2, 1'b1, "wait0");
                pulse();
                wait_state(4'd4, 1'b1, "drain0");
                repeat (3) pulse();
            end else begin
                for (int ep = 0; ep < int'(ne); ep++) begin
                    wait_state(4'd2, 1'b1, "wait_epoch");
                    pulse();
                    wait_state(4'd2, 1'b0, "leave_wait");
                end
            end
        end
        while (!done && n < 40000) begin
            @(negedge clk);
            n++;
        end
        check("done", {511'd0, done}, 512'd1);
        @(negedge clk);
        check("cmds_left", 512'(cmdq.size()), 512'd0);
        check("data_left", 512'(dq.size()), 512'd0);
        check("error_flags", {508'd0, err}, {508'd0, 2'b00, extra, dim == 0});
        check("epoch_index", {500'd0, sc[27:16]}, {500'd0, (dim == 0) ? 12'd0 : 12'(ne)});
        started = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #12;
        check("rst_rd_en", 512'(rd_en), 512'd0);
        check("rst_cmd", {415'd0, cmd_start, cmd_addr, cmd_len}, 512'd0);
        check("rst_data", {dvalid, dout[510:0]}, 512'd0);
        check("rst_misc", {475'd0, done, err, sc}, 512'd0);
        @(negedge clk) rst = 1'b0;
        repeat (2) @(negedge clk);

        run_job(512, 1, 64'h1000, 0);
        run_job(1500, 2, 64'h1000, 0);
        af_mode = 1; e3_mode = 1;
        run_job(2048, 2, 64'h20_0000, 0);
        af_mode = 0; e3_mode = 0;
        run_job(700, 2, 64'hABC0_0000, 1);
        run_job(0, 3, 64'h5000, 0);
        run_job(512, 0, 64'h6000, 0);

        build_model(1024, 1, 64'h8000);
        dimension = 1024; numEpochs = 1; addr_model = 64'h8000;
        @(negedge clk) started = 1'b1;
        wait_state(4'd2, 1'b1, "rst_wait");
        pulse();
        wait_state(4'd4, 1'b1, "rst_drain");
        repeat (10) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_rd_en", 512'(rd_en), 512'd0);
        check("midrst_cmd", {415'd0, cmd_start, cmd_addr, cmd_len}, 512'd0);
        check("midrst_data", {dvalid, dout[510:0]}, 512'd0);
        check("midrst_misc", {475'd0, done, err, sc}, 512'd0);
        cmdq.delete();
        dq.delete();
        for (int e = 0; e < E; e++) fq[e].delete();
        started = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        run_job(512, 1, 64'h40000, 0);

        for (int k = 0; k < 4; k++) begin
            af_mode = $urandom_range(0, 1);
            e3_mode = $urandom_range(0, 1);
            run_job($urandom_range(1, 2100), $urandom_range(1, 3),
                    {32'd0, $urandom} << 6, 0);
        end
        af_mode = 0; e3_mode = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
